// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
// The cache takes the slave modport. The fetch/memory environment takes the master modport.
interface icache_ctrl_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        flush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport slave (
      input  imemREN, imemaddr, flush, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, flush, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache. Hits are served with zero latency.
// A miss issues a single-word memory read, fills the set, then replays the lookup.
module icache_ctrl #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   icache_ctrl_if.slave     cif,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int unsigned SETS  = 2 ** IDX_W;
   localparam int unsigned TAG_W = 32 - IDX_W - 2;

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [SETS-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS];
   logic [29:0]      miss_addr_q, miss_addr_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             hit_c, fill_c;
   logic             unused_c;

   assign req_idx  = cif.imemaddr[IDX_W+1:2];
   assign req_tag  = cif.imemaddr[31:IDX_W+2];
   assign fill_idx = miss_addr_q[IDX_W-1:0];
   assign fill_tag = miss_addr_q[29:IDX_W];
   assign unused_c = ^cif.imemaddr[1:0];

   // Lookup only happens in IDLE; a flush in the same cycle suppresses the hit.
   assign hit_c = (state_q == IDLE) && cif.imemREN && !cif.flush &&
                  valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   assign cif.ihit     = hit_c;
   assign cif.imemload = hit_c ? data_q[req_idx] : 32'h0;
   assign cif.iREN     = (state_q == FETCH);
   assign cif.iaddr    = (state_q == FETCH) ? {miss_addr_q, 2'b00} : 32'h0;
   assign hit_cnt      = hit_cnt_q;
   assign miss_cnt     = miss_cnt_q;

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      valid_d     = valid_q;
      miss_cnt_d  = miss_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      fill_c      = 1'b0;

      if (hit_c && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (cif.imemREN && !hit_c && !cif.flush) begin
               state_d     = FETCH;
               miss_addr_d = cif.imemaddr[31:2];
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
         end
         FETCH: begin
            // A flush abandons the fill even if the data arrives in the same cycle.
            if (cif.flush) begin
               state_d = IDLE;
            end else if (!cif.iwait) begin
               fill_c  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fill_c)    valid_d[fill_idx] = 1'b1;
      if (cif.flush) valid_d = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         miss_addr_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         miss_addr_q <= miss_addr_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Tag/data storage carries no reset; valid bits gate its use.
   always_ff @(posedge CLK) begin
      if (fill_c) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= cif.iload;
      end
   end
endmodule
